// File: rtl/tuner_phy_pkg.sv
// Shared types for the ring tuner.
// Holds the state encoding of the main sequencer (exported on o_state_mon so
// software and benches can name the states) and a small decode helper.
package tuner_phy_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SEARCH_REQ,
    SEARCH_WAIT,
    SELECT,
    LOCK_REQ,
    LOCK_WAIT,
    LOCKED,
    RETRY,
    ERROR
  } tuner_ctrl_state_e;

  // Busy means "a sequence is in flight": everything but the resting states.
  function automatic logic is_busy(input tuner_ctrl_state_e s);
    return !(s inside {IDLE, LOCKED, ERROR});
  endfunction

endpackage

// File: rtl/tuner_timeout_cnt.sv
// Per-phase cycle timer for the tuner sequencer.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   clear     forces the count to zero (takes priority over enable)
//   enable    count one cycle; the count saturates at all-ones, never wraps
//   limit     timeout in cycles; 0 disables the timer
//   expired   high while count == limit-1, i.e. during the limit-th counted cycle
module tuner_timeout_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

  // Combinational so the owner can leave the wait state on the very next edge.
  assign expired = (limit != '0) && (count == limit - WIDTH'(1));

endmodule

// File: rtl/tuner_main_ctrl.sv
// Top-level sequencer for one ring tuner.
// Runs a search sweep, picks the configured target peak, hands its power/tune
// to the lock PHY and supervises lock; re-searches on lock loss or timeout,
// giving up into ERROR after MAX_RETRY retries.
// Ports:
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_start, i_abort           start pulse (IDLE/ERROR only), abort level
//   i_cfg_target_idx           peak index to lock onto (latched at start)
//   i_cfg_timeout              cycle limit for the *_WAIT states, 0 = none
//   o_search_req/i_search_ack  search request handshake
//   i_search_done, i_search_peak_cnt   sweep complete + number of peaks
//   o_search_peak_idx, i_search_peak_pwr/tune   peak table read, 1-cycle latency
//   o_lock_req/i_lock_ack      lock request handshake
//   i_lock_locked, i_lock_lost lock status level / loss pulse
//   o_cfg_pwr_peak, o_cfg_ring_tune_peak   selected peak to the lock PHY
//   o_state_mon, o_busy, o_locked, o_err, o_retry_cnt   status
module tuner_main_ctrl
  import tuner_phy_pkg::*;
#(
  parameter int DAC_WIDTH     = 8,
  parameter int ADC_WIDTH     = 8,
  parameter int NUM_TARGET    = 8,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int MAX_RETRY     = 3,
  localparam int IdxW   = $clog2(NUM_TARGET),
  localparam int CntW   = $clog2(NUM_TARGET + 1),
  localparam int RetryW = $clog2(MAX_RETRY + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic [IdxW-1:0]          i_cfg_target_idx,
  input  logic [TIMEOUT_WIDTH-1:0] i_cfg_timeout,
  output logic                     o_search_req,
  input  logic                     i_search_ack,
  input  logic                     i_search_done,
  input  logic [CntW-1:0]          i_search_peak_cnt,
  output logic [IdxW-1:0]          o_search_peak_idx,
  input  logic [ADC_WIDTH-1:0]     i_search_peak_pwr,
  input  logic [DAC_WIDTH-1:0]     i_search_peak_tune,
  output logic                     o_lock_req,
  input  logic                     i_lock_ack,
  input  logic                     i_lock_locked,
  input  logic                     i_lock_lost,
  output logic [ADC_WIDTH-1:0]     o_cfg_pwr_peak,
  output logic [DAC_WIDTH-1:0]     o_cfg_ring_tune_peak,
  output tuner_ctrl_state_e        o_state_mon,
  output logic                     o_busy,
  output logic                     o_locked,
  output logic                     o_err,
  output logic [RetryW-1:0]        o_retry_cnt
);

  tuner_ctrl_state_e state, state_nxt;
  logic [IdxW-1:0]   tgt;
  logic              sel_phase;   // 0: index driven, 1: table data valid
  logic              load_start;
  logic              retry_inc;
  logic              sel_capture;
  logic              timer_clear;
  logic              timer_en;
  logic              expired;

  // Timer restarts on every state change, so it always measures time spent
  // in the current wait state only.
  assign timer_clear = (state_nxt != state);
  assign timer_en    = (state == SEARCH_WAIT) || (state == LOCK_WAIT);

  tuner_timeout_cnt #(.WIDTH(TIMEOUT_WIDTH)) u_timeout (
    .clk     (i_clk),
    .rst     (i_rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .limit   (i_cfg_timeout),
    .expired (expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    load_start  = 1'b0;
    retry_inc   = 1'b0;
    sel_capture = 1'b0;
    if (i_abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, ERROR: begin
          if (i_start) begin
            state_nxt  = SEARCH_REQ;
            load_start = 1'b1;
          end
        end
        SEARCH_REQ: if (i_search_ack) state_nxt = SEARCH_WAIT;
        SEARCH_WAIT: begin
          // A completed sweep outranks a timeout in the same cycle.
          if (i_search_done)
            state_nxt = (i_search_peak_cnt > CntW'(tgt)) ? SELECT : RETRY;
          else if (expired)
            state_nxt = RETRY;
        end
        SELECT: begin
          if (sel_phase) begin
            state_nxt   = LOCK_REQ;
            sel_capture = 1'b1;
          end
        end
        LOCK_REQ: if (i_lock_ack) state_nxt = LOCK_WAIT;
        LOCK_WAIT: begin
          // Loss outranks a simultaneous locked indication.
          if (i_lock_lost || expired) state_nxt = RETRY;
          else if (i_lock_locked)     state_nxt = LOCKED;
        end
        LOCKED: if (i_lock_lost) state_nxt = RETRY;
        RETRY: begin
          if (o_retry_cnt == RetryW'(MAX_RETRY)) begin
            state_nxt = ERROR;
          end else begin
            state_nxt = SEARCH_REQ;
            retry_inc = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are computed from the next state so they line up with the state
  // register and change on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tgt                  <= '0;
      sel_phase            <= 1'b0;
      o_retry_cnt          <= '0;
      o_search_peak_idx    <= '0;
      o_cfg_pwr_peak       <= '0;
      o_cfg_ring_tune_peak <= '0;
      o_search_req         <= 1'b0;
      o_lock_req           <= 1'b0;
      o_busy               <= 1'b0;
      o_locked             <= 1'b0;
      o_err                <= 1'b0;
    end else begin
      sel_phase    <= (state == SELECT) && (state_nxt == SELECT);
      o_search_req <= (state_nxt == SEARCH_REQ);
      o_lock_req   <= (state_nxt == LOCK_REQ);
      o_busy       <= is_busy(state_nxt);
      o_locked     <= (state_nxt == LOCKED);
      o_err        <= (state_nxt == ERROR);
      if (load_start) begin
        tgt         <= i_cfg_target_idx;
        o_retry_cnt <= '0;
      end else if (retry_inc) begin
        o_retry_cnt <= o_retry_cnt + RetryW'(1);
      end
      // Present the read address on SELECT entry; data returns one cycle later.
      if ((state_nxt == SELECT) && (state != SELECT))
        o_search_peak_idx <= tgt;
      if (sel_capture) begin
        o_cfg_pwr_peak       <= i_search_peak_pwr;
        o_cfg_ring_tune_peak <= i_search_peak_tune;
      end
    end
  end

  assign o_state_mon = state;

endmodule
